// File: rtl/gcd_job_driver.sv
// Initiator for the GCD core's Start/Ack/q_Done handshake: takes an operand pair on a
// valid/ready request port, runs one core job and returns the result on a valid/ready response port.
module gcd_job_driver #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             SCEN,
    input  logic             Req_valid,
    output logic             Req_ready,
    input  logic [WIDTH-1:0] Req_a,
    input  logic [WIDTH-1:0] Req_b,
    output logic             Start,
    output logic             Ack,
    output logic [WIDTH-1:0] Ain,
    output logic [WIDTH-1:0] Bin,
    input  logic             q_Done,
    input  logic [WIDTH-1:0] AB_GCD,
    output logic             Rsp_valid,
    input  logic             Rsp_ready,
    output logic [WIDTH-1:0] Rsp_gcd,
    output logic [1:0]       Rsp_err,
    output logic [CW-1:0]    Rsp_cycles,
    output logic             Busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [1:0]    ERR_OK      = 2'b00;
    localparam logic [1:0]    ERR_ZERO    = 2'b01;
    localparam logic [1:0]    ERR_TIMEOUT = 2'b10;
    localparam logic [CW-1:0] TIMEOUT_C   = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE_C       = CW'(1);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] ain_s;
    logic [WIDTH-1:0] bin_s;
    logic [WIDTH-1:0] gcd_s;
    logic [1:0]       err_s;
    logic [CW-1:0]    cycles_s;
    logic [CW-1:0]    cycles_inc_s;

    assign cycles_inc_s = Rsp_cycles + ONE_C;

    // Next-state and next-data decode; a zero operand skips the core, which would never finish.
    always_comb begin
        state_s  = state_r;
        ain_s    = Ain;
        bin_s    = Bin;
        gcd_s    = Rsp_gcd;
        err_s    = Rsp_err;
        cycles_s = Rsp_cycles;
        case (state_r)
            ST_IDLE: begin
                if (Req_valid && Req_ready) begin
                    ain_s    = Req_a;
                    bin_s    = Req_b;
                    cycles_s = {CW{1'b0}};
                    if ((Req_a == {WIDTH{1'b0}}) || (Req_b == {WIDTH{1'b0}})) begin
                        err_s   = ERR_ZERO;
                        gcd_s   = {WIDTH{1'b0}};
                        state_s = ST_RESP;
                    end else begin
                        state_s = ST_START;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: state_s = ST_WAIT;
            ST_WAIT: begin
                cycles_s = cycles_inc_s;
                if (q_Done) begin
                    gcd_s   = AB_GCD;
                    err_s   = ERR_OK;
                    state_s = ST_ACK;
                end else if (cycles_inc_s == TIMEOUT_C) begin
                    gcd_s   = {WIDTH{1'b0}};
                    err_s   = ERR_TIMEOUT;
                    state_s = ST_ACK;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ACK: state_s = ST_RESP;
            ST_RESP: begin
                if (Rsp_valid && Rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State and output registers; control flags are decoded from the next state so every output is a flop.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r    <= ST_IDLE;
            Req_ready  <= 1'b1;
            Start      <= 1'b0;
            Ack        <= 1'b0;
            Rsp_valid  <= 1'b0;
            Busy       <= 1'b0;
            Ain        <= {WIDTH{1'b0}};
            Bin        <= {WIDTH{1'b0}};
            Rsp_gcd    <= {WIDTH{1'b0}};
            Rsp_err    <= ERR_OK;
            Rsp_cycles <= {CW{1'b0}};
        end else if (SCEN) begin
            state_r    <= state_s;
            Req_ready  <= (state_s == ST_IDLE);
            Start      <= (state_s == ST_START);
            Ack        <= (state_s == ST_ACK);
            Rsp_valid  <= (state_s == ST_RESP);
            Busy       <= (state_s != ST_IDLE);
            Ain        <= ain_s;
            Bin        <= bin_s;
            Rsp_gcd    <= gcd_s;
            Rsp_err    <= err_s;
            Rsp_cycles <= cycles_s;
        end
    end

endmodule

// File: tb/tb_gcd_job_driver.sv
// Directed bench for gcd_job_driver: a behavioural subtract-loop GCD core on one instance,
// a stuck-q_Done stub with TIMEOUT=16 on a second.
module tb_gcd_job_driver;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       SCEN;
    logic       Req_valid, Req_ready, Start, Ack, q_Done, Rsp_valid, Rsp_ready, Busy;
    logic [7:0] Req_a, Req_b, Ain, Bin, AB_GCD, Rsp_gcd, Rsp_cycles;
    logic [1:0] Rsp_err;

    logic       b_req_valid, b_req_ready, b_start, b_ack, b_rsp_valid, b_rsp_ready, b_busy;
    logic [7:0] b_req_a, b_req_b, b_ain, b_bin, b_rsp_gcd, b_rsp_cycles;
    logic [1:0] b_rsp_err;

    int vec_count = 0;
    int err_count = 0;

    always #5 Clk = ~Clk;

    gcd_job_driver #(.WIDTH(8), .TIMEOUT(255), .CW(8)) dut (
        .Clk(Clk), .Reset(Reset), .SCEN(SCEN),
        .Req_valid(Req_valid), .Req_ready(Req_ready), .Req_a(Req_a), .Req_b(Req_b),
        .Start(Start), .Ack(Ack), .Ain(Ain), .Bin(Bin), .q_Done(q_Done), .AB_GCD(AB_GCD),
        .Rsp_valid(Rsp_valid), .Rsp_ready(Rsp_ready), .Rsp_gcd(Rsp_gcd), .Rsp_err(Rsp_err),
        .Rsp_cycles(Rsp_cycles), .Busy(Busy)
    );

    gcd_job_driver #(.WIDTH(8), .TIMEOUT(16), .CW(8)) dut_to (
        .Clk(Clk), .Reset(Reset), .SCEN(1'b1),
        .Req_valid(b_req_valid), .Req_ready(b_req_ready), .Req_a(b_req_a), .Req_b(b_req_b),
        .Start(b_start), .Ack(b_ack), .Ain(b_ain), .Bin(b_bin), .q_Done(1'b0), .AB_GCD(8'hAA),
        .Rsp_valid(b_rsp_valid), .Rsp_ready(b_rsp_ready), .Rsp_gcd(b_rsp_gcd), .Rsp_err(b_rsp_err),
        .Rsp_cycles(b_rsp_cycles), .Busy(b_busy)
    );

    // Behavioural GCD core: loads on Start, subtracts until equal, holds done until Ack.
    typedef enum logic [1:0] {C_INIT, C_COMP, C_DONE} core_t;
    core_t      cst;
    logic [7:0] ca, cb;
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cst <= C_INIT;
            ca  <= 8'd0;
            cb  <= 8'd0;
        end else if (SCEN) begin
            case (cst)
                C_INIT: if (Start) begin ca <= Ain; cb <= Bin; cst <= C_COMP; end
                C_COMP: begin
                    if (ca == cb) cst <= C_DONE;
                    else if (ca > cb) ca <= ca - cb;
                    else cb <= cb - ca;
                end
                C_DONE: if (Ack) cst <= C_INIT;
                default: cst <= C_INIT;
            endcase
        end
    end
    assign q_Done = (cst == C_DONE);
    assign AB_GCD = ca;

    logic [38:0] outs;
    assign outs = {Req_ready, Start, Ack, Ain, Bin, Rsp_valid, Rsp_gcd, Rsp_err, Rsp_cycles, Busy};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            err_count++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One job on the main instance with Rsp_ready high; es=1 means the core is expected to run.
    task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eg,
                           input logic [1:0] ee, input int es);
        int t, starts, acks, qd_t, rv_t, st_t;
        @(negedge Clk);
        check("req_ready_idle", Req_ready, 1);
        Req_a = a; Req_b = b; Req_valid = 1'b1; Rsp_ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Req_valid = 1'b0;
        check("req_ready_busy", Req_ready, 0);
        check("busy_high", Busy, 1);
        t = 1; starts = 0; acks = 0; qd_t = -1; rv_t = -1; st_t = -1;
        for (int i = 0; i < 300; i++) begin
            if (Start) begin starts++; if (st_t < 0) st_t = t; end
            if (Ack) acks++;
            if (Start && Ack) check("start_and_ack", 1, 0);
            if (q_Done && qd_t < 0) qd_t = t;
            if (Rsp_valid) begin rv_t = t; break; end
            @(negedge Clk);
            t++;
        end
        if (rv_t < 0) begin
            check("rsp_wait_bound", 0, 1);
        end else begin
            check("rsp_gcd", Rsp_gcd, eg);
            check("rsp_err", Rsp_err, ee);
            check("ain_held", Ain, a);
            check("bin_held", Bin, b);
            check("start_cycles", starts, es);
            check("ack_cycles", acks, es);
            if (es != 0) begin
                check("start_latency", st_t, 1);
                check("rsp_after_done", rv_t, qd_t + 2);
                check("rsp_cycles", Rsp_cycles, qd_t - 1);
            end else begin
                check("rsp_latency_zero", rv_t, 1);
                check("rsp_cycles_zero", Rsp_cycles, 0);
            end
            @(negedge Clk);
            check("rsp_valid_drop", Rsp_valid, 0);
            check("req_ready_back", Req_ready, 1);
        end
    endtask

    initial begin
        int t, st, acks, ack_t, p, bp;
        logic [38:0] snap;
        logic [3:0]  pat;
        logic        prev_scen, seen_rsp, done;

        Reset = 1'b0; SCEN = 1'b1;
        Req_valid = 1'b0; Req_a = 8'd0; Req_b = 8'd0; Rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_a = 8'd0; b_req_b = 8'd0; b_rsp_ready = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_req_ready", Req_ready, 1);
        check("rst_busy", Busy, 0);
        check("rst_start_ack", {Start, Ack}, 0);
        check("rst_ain_bin", {Ain, Bin}, 0);
        check("rst_rsp", {Rsp_valid, Rsp_gcd, Rsp_err, Rsp_cycles}, 0);
        Reset = 1'b1;

        // Basic job, back-to-back jobs, zero operand
        run_job(8'd36, 8'd24, 8'd12, 2'b00, 1);
        run_job(8'd5, 8'd15, 8'd5, 2'b00, 1);
        run_job(8'd255, 8'd17, 8'd17, 2'b00, 1);
        run_job(8'd0, 8'd9, 8'd0, 2'b01, 0);

        // Timeout on the stub instance: 16 WAIT cycles, Ack in cycle 18, response in 19
        @(negedge Clk);
        b_req_a = 8'd7; b_req_b = 8'd3; b_req_valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        b_req_valid = 1'b0;
        t = 1; st = 0; acks = 0; ack_t = -1; done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (b_start) st++;
            if (b_ack) begin acks++; ack_t = t; end
            if (b_rsp_valid) begin done = 1'b1; break; end
            @(negedge Clk);
            t++;
        end
        check("to_rsp_seen", done, 1);
        check("to_start_cycles", st, 1);
        check("to_ack_cycles", acks, 1);
        check("to_ack_time", ack_t, 18);
        check("to_rsp_time", t, 19);
        check("to_err", b_rsp_err, 2'b10);
        check("to_gcd", b_rsp_gcd, 0);
        check("to_cycles", b_rsp_cycles, 16);
        @(negedge Clk);
        check("to_idle", b_req_ready, 1);

        // SCEN 1-0-0-1 with 5 cycles of response backpressure
        pat = 4'b1001;
        @(negedge Clk);
        Req_a = 8'd36; Req_b = 8'd24; Req_valid = 1'b1; Rsp_ready = 1'b0;
        SCEN = pat[0]; p = 1; snap = outs; prev_scen = SCEN;
        seen_rsp = 1'b0; done = 1'b0; bp = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (!prev_scen) check("scen_freeze", outs, snap);
            if (Start && Ack) check("sc_start_and_ack", 1, 0);
            if (Req_valid && !Req_ready) Req_valid = 1'b0;
            if (Rsp_valid) begin
                seen_rsp = 1'b1;
                check("bp_gcd", Rsp_gcd, 12);
                check("bp_err", Rsp_err, 0);
                if (!Rsp_ready) bp++;
                if (bp >= 5) Rsp_ready = 1'b1;
            end
            if (seen_rsp && !Rsp_valid) begin
                done = 1'b1;
                check("sc_req_ready_back", Req_ready, 1);
                break;
            end
            SCEN = pat[p % 4];
            p++;
            snap = outs;
            prev_scen = SCEN;
        end
        check("sc_job_done", done, 1);
        check("sc_backpressure", bp, 5);
        SCEN = 1'b1; Rsp_ready = 1'b1;

        // Asynchronous reset in the middle of WAIT, then a fresh job
        @(negedge Clk);
        Req_a = 8'd36; Req_b = 8'd24; Req_valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Req_valid = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #3;
        check("pre_reset_busy", Busy, 1);
        Reset = 1'b0;
        #1;
        check("ar_req_ready", Req_ready, 1);
        check("ar_busy", Busy, 0);
        check("ar_start_ack", {Start, Ack}, 0);
        check("ar_ain_bin", {Ain, Bin}, 0);
        check("ar_rsp", {Rsp_valid, Rsp_gcd, Rsp_err, Rsp_cycles}, 0);
        @(negedge Clk);
        Reset = 1'b1;
        run_job(8'd48, 8'd18, 8'd6, 2'b00, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
